// File: rtl/store_buffer_if.sv
// Pipeline/memory-side bundle for the store buffer: store handshake, load-forward
// lookup, and the drain write port into data_memory.
interface store_buffer_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 3
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_busy,
    input  st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_busy,
    output st_ready, ld_hit, ld_data, mem_we, mem_addr, mem_wdata, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between MEM stage and data_memory: queues retired stores,
// drains one per idle memory cycle, and forwards the youngest match to loads.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  store_buffer_if.slave   sb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q  [DEPTH];
  logic [AW-1:0] addr_d  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [DW-1:0] data_d  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          drain;
  logic          full;
  logic          hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  assign full  = (count_q == CW'(DEPTH));
  assign drain = (count_q != '0) && !sb.mem_busy;
  assign push  = sb.st_valid && !full;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q]  = sb.st_addr;
      data_d[tail_q]  = sb.st_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    // head==tail only when full (no push) or empty (no drain), so no slot clash
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx] == sb.ld_addr)) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign sb.st_ready  = !full;
  assign sb.mem_we    = drain;
  assign sb.mem_addr  = addr_q[head_q];
  assign sb.mem_wdata = data_q[head_q];
  assign sb.ld_hit    = hit;
  assign sb.ld_data   = fwd_data;
  assign sb.empty     = (count_q == '0);
  assign sb.count     = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: reset, latency, full/hold, forwarding,
// simultaneous enqueue/drain and wrap-around ordering with a toggling memory port.
module tb_store_buffer;
  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [7:0] mem [256];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];
  logic       over_full;
  int         n;

  store_buffer_if #(.AW(8), .DW(8), .CW(3)) sb ();

  store_buffer #(.DEPTH(4), .AW(8), .DW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and write log; negedge sampling sees the final drain request.
  always @(negedge clk) begin
    if (reset && sb.mem_we) begin
      mem[sb.mem_addr] = sb.mem_wdata;
      wr_addr.push_back(sb.mem_addr);
      wr_data.push_back(sb.mem_wdata);
    end
    if (sb.count > 3'd4) over_full = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain_all(input string tag);
    sb.st_valid = 1'b0;
    sb.mem_busy = 1'b0;
    for (int k = 0; k < 20 && !sb.empty; k++) step();
    chk(tag, 32'(sb.empty), 32'd1);
  endtask

  initial begin
    total = 0; bad = 0; over_full = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b0;
    sb.st_valid = 1'b0; sb.st_addr = '0; sb.st_data = '0;
    sb.ld_addr = '0; sb.mem_busy = 1'b0;
    #3;
    chk("rst_ready", 32'(sb.st_ready), 32'd1);
    chk("rst_empty", 32'(sb.empty), 32'd1);
    chk("rst_we", 32'(sb.mem_we), 32'd0);
    chk("rst_count", 32'(sb.count), 32'd0);
    chk("rst_maddr", 32'(sb.mem_addr), 32'd0);
    chk("rst_mdata", 32'(sb.mem_wdata), 32'd0);
    chk("rst_hit", 32'(sb.ld_hit), 32'd0);
    chk("rst_ldata", 32'(sb.ld_data), 32'd0);
    #4 reset = 1'b1;
    step();

    // 1: reset mid-drain
    sb.mem_busy = 1'b1;
    sb.st_valid = 1'b1; sb.st_addr = 8'h01; sb.st_data = 8'h11; step();
    sb.st_addr = 8'h02; sb.st_data = 8'h22; step();
    sb.st_valid = 1'b0;
    chk("t1_count2", 32'(sb.count), 32'd2);
    sb.mem_busy = 1'b0;
    #1 chk("t1_we_pre", 32'(sb.mem_we), 32'd1);
    reset = 1'b0;
    #1 chk("t1_we_drop", 32'(sb.mem_we), 32'd0);
    step();
    reset = 1'b1;
    sb.ld_addr = 8'h01;
    #1;
    chk("t1_empty", 32'(sb.empty), 32'd1);
    chk("t1_count", 32'(sb.count), 32'd0);
    chk("t1_ready", 32'(sb.st_ready), 32'd1);
    chk("t1_hit", 32'(sb.ld_hit), 32'd0);
    step();
    chk("t1_nowrite", 32'(wr_addr.size()), 32'd0);
    wr_addr.delete(); wr_data.delete();

    // 2: single store latency
    sb.st_valid = 1'b1; sb.st_addr = 8'h34; sb.st_data = 8'h12;
    #1 chk("t2_no_passthru", 32'(sb.mem_we), 32'd0);
    step();
    sb.st_valid = 1'b0;
    chk("t2_we", 32'(sb.mem_we), 32'd1);
    chk("t2_addr", 32'(sb.mem_addr), 32'h34);
    chk("t2_data", 32'(sb.mem_wdata), 32'h12);
    step();
    chk("t2_we_off", 32'(sb.mem_we), 32'd0);
    chk("t2_empty", 32'(sb.empty), 32'd1);
    chk("t2_mem", 32'(mem[8'h34]), 32'h12);
    chk("t2_nwr", 32'(wr_addr.size()), 32'd1);
    wr_addr.delete(); wr_data.delete();

    // 3: fill, hold fifth store, drain in order
    sb.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.st_valid = 1'b1; sb.st_addr = 8'(8'h10 + i); sb.st_data = 8'(8'hA0 + i);
      step();
    end
    chk("t3_count4", 32'(sb.count), 32'd4);
    chk("t3_notready", 32'(sb.st_ready), 32'd0);
    sb.st_addr = 8'h14; sb.st_data = 8'hA4;
    step();
    chk("t3_held", 32'(sb.count), 32'd4);
    sb.mem_busy = 1'b0;
    #1 chk("t3_head", 32'(sb.mem_addr), 32'h10);
    step();
    chk("t3_count3", 32'(sb.count), 32'd3);
    chk("t3_ready", 32'(sb.st_ready), 32'd1);
    step();
    sb.st_valid = 1'b0;
    chk("t3_accept", 32'(sb.count), 32'd3);
    drain_all("t3_empty");
    chk("t3_nwr", 32'(wr_addr.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_addr.size(); i++) begin
      chk($sformatf("t3_addr%0d", i), 32'(wr_addr[i]), 32'(8'h10 + i));
      chk($sformatf("t3_data%0d", i), 32'(wr_data[i]), 32'(8'hA0 + i));
    end
    wr_addr.delete(); wr_data.delete();

    // 4: youngest-match forwarding
    sb.mem_busy = 1'b1;
    sb.st_valid = 1'b1; sb.st_addr = 8'h20; sb.st_data = 8'hAA; step();
    sb.st_data = 8'hBB; step();
    sb.st_valid = 1'b0;
    sb.ld_addr = 8'h20;
    #1;
    chk("t4_hit", 32'(sb.ld_hit), 32'd1);
    chk("t4_data", 32'(sb.ld_data), 32'hBB);
    sb.ld_addr = 8'h21;
    #1;
    chk("t4_miss", 32'(sb.ld_hit), 32'd0);
    chk("t4_missdata", 32'(sb.ld_data), 32'h00);
    sb.st_valid = 1'b1; sb.st_addr = 8'h21; sb.st_data = 8'hCC;
    #1 chk("t4_nofwd_st", 32'(sb.ld_hit), 32'd0);
    sb.st_valid = 1'b0;
    sb.ld_addr = 8'h20; sb.mem_busy = 1'b0;
    #1 chk("t4_drainfwd", 32'(sb.ld_data), 32'hBB);
    drain_all("t4_empty");
    chk("t4_mem", 32'(mem[8'h20]), 32'hBB);
    wr_addr.delete(); wr_data.delete();

    // 5: enqueue and drain in the same cycle
    sb.mem_busy = 1'b1;
    sb.st_valid = 1'b1; sb.st_addr = 8'h40; sb.st_data = 8'h01; step();
    sb.st_addr = 8'h41; sb.st_data = 8'h02; step();
    chk("t5_count2", 32'(sb.count), 32'd2);
    sb.mem_busy = 1'b0; sb.st_addr = 8'h42; sb.st_data = 8'h03;
    #1 chk("t5_head", 32'(sb.mem_addr), 32'h40);
    step();
    sb.st_valid = 1'b0;
    chk("t5_count", 32'(sb.count), 32'd2);
    chk("t5_newhead", 32'(sb.mem_addr), 32'h41);
    drain_all("t5_empty");
    chk("t5_nwr", 32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3 && i < wr_addr.size(); i++)
      chk($sformatf("t5_addr%0d", i), 32'(wr_addr[i]), 32'(8'h40 + i));
    wr_addr.delete(); wr_data.delete();

    // 6: ten stores with the memory port toggling
    n = 0;
    for (int cyc = 0; cyc < 100 && (n < 10 || !sb.empty); cyc++) begin
      sb.mem_busy = cyc[0];
      sb.st_valid = (n < 10);
      sb.st_addr  = 8'(8'h50 + n);
      sb.st_data  = 8'(8'h60 + n);
      #1;
      if (sb.st_valid && sb.st_ready) n++;
      step();
    end
    sb.st_valid = 1'b0; sb.mem_busy = 1'b0;
    chk("t6_sent", 32'(n), 32'd10);
    chk("t6_empty", 32'(sb.empty), 32'd1);
    chk("t6_nwr", 32'(wr_addr.size()), 32'd10);
    for (int i = 0; i < 10 && i < wr_addr.size(); i++) begin
      chk($sformatf("t6_addr%0d", i), 32'(wr_addr[i]), 32'(8'h50 + i));
      chk($sformatf("t6_data%0d", i), 32'(wr_data[i]), 32'(8'h60 + i));
    end
    chk("never_over4", 32'(over_full), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
